mx_seu_pipe: RTL and testbench
==============================

// Module: mx_seu_pipe
// PURPOSE
// Parametrised, pipelined successor to the MX11 single-cycle execution unit. It accepts one ALU
// instruction per valid/ready handshake and taps operands from the flat register line. It
// computes the result with a built-in ALU and returns a registered writeback with bank select
// and a merged flag register. Sits between the instruction decoder and the register file, and
// adds operand forwarding, writeback back-pressure and an optional multi-cycle multiply.
// PARAMETERS
// DATA_WIDTH  8        register/operand width, >=8
// DEPTH       16       number of registers on reg_line; AW=$clog2(DEPTH)
// FLAG_IDX    7        register index holding flags; bits[4:0]={Z,C,N,V,P}, upper bits preserved
// BANK1_MASK  16'h3F08 bit k set -> opcode k writes back to bank 1 (unless fetch)
// PORTS
// clk        in   1            clock
// rst        in   1            synchronous active-high reset
// in_valid   in   1            instruction present
// in_ready   out  1            unit can accept this cycle
// opcode     in   4            0 PASS,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 NOT,7 SHL,8 SHR,9 ADC,A SBB,B CMP,C INC,D DEC,E MUL,F NOP
// src_a      in   AW           operand A register index
// src_b      in   AW           operand B register index
// dst_f      in   AW           destination register index
// ldi        in   1            replace operand A with ldv
// ldv        in   DATA_WIDTH   immediate value
// fetch      in   1            force writeback bank 0
// reg_line   in   DEPTH*DW     flat register file contents
// wb_valid   out  1            writeback pending
// wb_ready   in   1            register file accepts writeback
// wb_we      out  1            write wb_data to wb_addr
// wb_addr    out  AW           destination index
// wb_bank    out  1            destination bank
// wb_data    out  DATA_WIDTH   result
// wb_flag_we out  1            write wb_flags to register FLAG_IDX
// wb_flags   out  DATA_WIDTH   {reg[FLAG_IDX][DW-1:5], Z,C,N,V,P}
// BEHAVIOUR
// - Reset: in_ready=0 during rst, 1 the cycle after; wb_valid, wb_we and wb_flag_we = 0;
//   wb_addr, wb_bank, wb_data and wb_flags = 0. MUL state idle.
// - Accept when in_valid&&in_ready. in_ready = !mul_busy && (!wb_valid || wb_ready).
// - Single-cycle ops: accepted cycle N -> wb_valid high at N+1. wb_* held stable until wb_ready.
// - Writeback fires on wb_valid&&wb_ready. The register file shows the write on reg_line from
//   the next cycle.
// - Forwarding: if a writeback fires in the accept cycle and wb_we && wb_addr==src, forward
//   wb_data. Flags are forwarded from wb_flags when wb_flag_we is set.
// - Operand A is ldv when ldi=1; operand B has no immediate path.
// - Arithmetic is modulo 2^DW. C = carry out (ADD/ADC/INC), borrow (SUB/SBB/CMP/DEC), or the
//   bit shifted out (SHL/SHR). V = signed overflow. Z = result==0. N = result MSB. P = even parity.
// - Logic ops and PASS/NOT clear C and V. ADC/SBB use C from the current (forwarded) flag register.
// - CMP: wb_we=0, wb_flag_we=1. NOP: wb_valid pulses with wb_we=0 and wb_flag_we=0. All other
//   ops: wb_we=1, wb_flag_we=1.
// - Flag conflict: if dst_f==FLAG_IDX and wb_we, the wb_data write wins. The register file
//   applies wb_flags first, then wb_data.
// - wb_bank = fetch ? 0 : BANK1_MASK[opcode].
// - MUL FSM: IDLE -> MUL (DW shift-add iterations, one per cycle, mul_busy=1) -> DONE.
//   wb_valid rises at N+DW. Result = low DW bits of the product. C = (high half != 0), V = 0.
// - rst mid-MUL aborts the operation, so no writeback is produced.
// - Simultaneous writeback fire and new accept in the same cycle: the new result loads in the
//   same edge, giving back-to-back throughput of 1/cycle.
// CONFIGURATION
// MXSEU_MUL_EN defined: opcode E runs the iterative MUL described above.
// MXSEU_MUL_EN undefined: no multiplier logic. Opcode E behaves exactly as NOP (1-cycle
//   latency, wb_we=0, wb_flag_we=0), and mul_busy is tied to 0.
// TESTING
// 1. rst high 3 cycles then low -> wb_valid=0 throughout; in_ready=0 during rst, 1 after.
// 2. r1=8'h7F, r2=8'h01, ADD dst 3 -> wb_data=8'h80, V=1, N=1, C=0, Z=0, wb_bank=0.
// 3. ADD r3<=r1+r2 back-to-back with SUB r4<=r3-r2, wb_ready=1 -> SUB uses forwarded 8'h80,
//    wb_data=8'h7F, throughput 1 instruction/cycle.
// 4. wb_ready=0 for 4 cycles with wb_valid=1 -> in_ready=0 and wb_* stable. wb_ready=1 ->
//    fires once, and the next instruction is accepted on the same cycle.
// 5. MUL_EN: 8'h10*8'h11 -> wb_valid at N+8, wb_data=8'h10, C=1. A second MUL with rst at
//    N+3 produces no writeback.
// 6. CMP r1=5 vs ldi ldv=5 -> wb_we=0, wb_flag_we=1, Z=1, C=0. fetch=1 with opcode 8 ->
//    wb_bank=0; fetch=0 -> wb_bank=1.

Source files
------------

// File: rtl/mx_seu_pipe.sv
// Pipelined execution unit: operand forwarding, registered writeback with back-pressure.
// Define MXSEU_MUL_EN to build the iterative shift-add multiplier for opcode E.
module mx_seu_pipe #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FLAG_IDX   = 7,
   parameter logic [15:0] BANK1_MASK = 16'h3F08,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [3:0]                  opcode,
   input  logic [AW-1:0]               src_a,
   input  logic [AW-1:0]               src_b,
   input  logic [AW-1:0]               dst_f,
   input  logic                        ldi,
   input  logic [DATA_WIDTH-1:0]       ldv,
   input  logic                        fetch,
   input  logic [DEPTH*DATA_WIDTH-1:0] reg_line,
   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic                        wb_we,
   output logic [AW-1:0]               wb_addr,
   output logic                        wb_bank,
   output logic [DATA_WIDTH-1:0]       wb_data,
   output logic                        wb_flag_we,
   output logic [DATA_WIDTH-1:0]       wb_flags
);

   localparam int unsigned DW = DATA_WIDTH;
   localparam logic [AW-1:0] FLAG_A = AW'(FLAG_IDX);

   localparam logic [3:0] OpPass = 4'h0, OpAdd = 4'h1, OpSub = 4'h2, OpAnd = 4'h3;
   localparam logic [3:0] OpOr   = 4'h4, OpXor = 4'h5, OpNot = 4'h6, OpShl = 4'h7;
   localparam logic [3:0] OpShr  = 4'h8, OpAdc = 4'h9, OpSbb = 4'hA, OpCmp = 4'hB;
   localparam logic [3:0] OpInc  = 4'hC, OpDec = 4'hD, OpMul = 4'hE;

   logic          fire, accept, mul_busy, is_mul;
   logic [DW-1:0] reg_fwd [DEPTH];
   logic [DW-1:0] a_op, b_op, arith_b, alu_res;
   logic [DW:0]   add_sum, sub_dif;
   logic          arith_ci, alu_c, alu_v, alu_we, alu_fe, bank_d;

   assign fire     = wb_valid && wb_ready;
   assign in_ready = !rst && !mul_busy && (!wb_valid || wb_ready);
   assign accept   = in_valid && in_ready;

   // Each entry shows what the register file will hold after a writeback firing this cycle;
   // a data write to the flag register overrides the flag write.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         reg_fwd[i] = reg_line[i*DW +: DW];
         if (fire && wb_flag_we && (i == FLAG_IDX)) reg_fwd[i] = wb_flags;
         if (fire && wb_we && (wb_addr == AW'(i)))  reg_fwd[i] = wb_data;
      end
   end

   assign a_op     = ldi ? ldv : reg_fwd[src_a];
   assign b_op     = reg_fwd[src_b];
   assign arith_b  = (opcode == OpInc || opcode == OpDec) ? DW'(1) : b_op;
   assign arith_ci = (opcode == OpAdc || opcode == OpSbb) ? reg_fwd[FLAG_A][3] : 1'b0;
   assign add_sum  = {1'b0, a_op} + {1'b0, arith_b} + {{DW{1'b0}}, arith_ci};
   // Bit DW of the difference is the borrow out.
   assign sub_dif  = {1'b0, a_op} - {1'b0, arith_b} - {{DW{1'b0}}, arith_ci};
   assign bank_d   = fetch ? 1'b0 : BANK1_MASK[opcode];

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_we  = 1'b1;
      alu_fe  = 1'b1;
      case (opcode)
         OpPass: alu_res = a_op;
         OpAdd, OpAdc, OpInc: begin
            alu_res = add_sum[DW-1:0];
            alu_c   = add_sum[DW];
            alu_v   = (a_op[DW-1] == arith_b[DW-1]) && (add_sum[DW-1] != a_op[DW-1]);
         end
         OpSub, OpSbb, OpCmp, OpDec: begin
            alu_res = sub_dif[DW-1:0];
            alu_c   = sub_dif[DW];
            alu_v   = (a_op[DW-1] != arith_b[DW-1]) && (sub_dif[DW-1] != a_op[DW-1]);
            alu_we  = (opcode != OpCmp);
         end
         OpAnd: alu_res = a_op & b_op;
         OpOr:  alu_res = a_op | b_op;
         OpXor: alu_res = a_op ^ b_op;
         OpNot: alu_res = ~a_op;
         OpShl: begin
            alu_res = {a_op[DW-2:0], 1'b0};
            alu_c   = a_op[DW-1];
         end
         OpShr: begin
            alu_res = {1'b0, a_op[DW-1:1]};
            alu_c   = a_op[0];
         end
         default: begin
            // NOP, and opcode E when the multiplier is not built.
            alu_we = 1'b0;
            alu_fe = 1'b0;
         end
      endcase
   end

`ifdef MXSEU_MUL_EN
   localparam int unsigned CW = $clog2(DW);

   typedef enum logic [1:0] {StIdle, StMul, StDone} mul_state_e;
   mul_state_e        mul_state_q, mul_state_d;
   logic              mul_done;
   logic [CW-1:0]     mul_cnt_q;
   logic [2*DW-1:0]   mul_acc_q, mul_mcand_q, mul_acc_nxt;
   logic [DW-1:0]     mul_mplier_q;
   logic [AW-1:0]     mul_addr_q;
   logic              mul_bank_q;
   logic [DW-6:0]     mul_fhi_q;

   assign is_mul      = (opcode == OpMul);
   assign mul_busy    = (mul_state_q == StMul);
   assign mul_acc_nxt = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);

   // Iteration 0 happens on the accept edge, so the last one lands the result at N+DW.
   always_comb begin
      mul_state_d = mul_state_q;
      mul_done    = 1'b0;
      case (mul_state_q)
         StMul: begin
            if (mul_cnt_q == CW'(DW-1)) begin
               mul_done    = 1'b1;
               mul_state_d = StDone;
            end
         end
         default: mul_state_d = (accept && is_mul) ? StMul : StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) mul_state_q <= StIdle;
      else     mul_state_q <= mul_state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_cnt_q    <= '0;
         mul_acc_q    <= '0;
         mul_mcand_q  <= '0;
         mul_mplier_q <= '0;
         mul_addr_q   <= '0;
         mul_bank_q   <= 1'b0;
         mul_fhi_q    <= '0;
      end else if (accept && is_mul) begin
         mul_cnt_q    <= CW'(1);
         mul_acc_q    <= b_op[0] ? {{DW{1'b0}}, a_op} : '0;
         mul_mcand_q  <= {{(DW-1){1'b0}}, a_op, 1'b0};
         mul_mplier_q <= {1'b0, b_op[DW-1:1]};
         mul_addr_q   <= dst_f;
         mul_bank_q   <= bank_d;
         mul_fhi_q    <= reg_fwd[FLAG_A][DW-1:5];
      end else if (mul_busy) begin
         mul_cnt_q    <= mul_cnt_q + CW'(1);
         mul_acc_q    <= mul_acc_nxt;
         mul_mcand_q  <= mul_mcand_q << 1;
         mul_mplier_q <= mul_mplier_q >> 1;
      end
   end
`else
   assign is_mul   = 1'b0;
   assign mul_busy = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_flag_we <= 1'b0;
         wb_addr    <= '0;
         wb_bank    <= 1'b0;
         wb_data    <= '0;
         wb_flags   <= '0;
      end else if (accept && !is_mul) begin
         wb_valid   <= 1'b1;
         wb_we      <= alu_we;
         wb_flag_we <= alu_fe;
         wb_addr    <= dst_f;
         wb_bank    <= bank_d;
         wb_data    <= alu_res;
         wb_flags   <= {reg_fwd[FLAG_A][DW-1:5], ~|alu_res, alu_c, alu_res[DW-1], alu_v,
                        ~^alu_res};
      end
`ifdef MXSEU_MUL_EN
      else if (mul_done) begin
         wb_valid   <= 1'b1;
         wb_we      <= 1'b1;
         wb_flag_we <= 1'b1;
         wb_addr    <= mul_addr_q;
         wb_bank    <= mul_bank_q;
         wb_data    <= mul_acc_nxt[DW-1:0];
         wb_flags   <= {mul_fhi_q, ~|mul_acc_nxt[DW-1:0], |mul_acc_nxt[2*DW-1:DW],
                        mul_acc_nxt[DW-1], 1'b0, ~^mul_acc_nxt[DW-1:0]};
      end
`endif
      else if (fire) begin
         wb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mx_seu_pipe.sv
// Self-checking bench for mx_seu_pipe: directed scenarios plus random traffic against an
// in-order architectural model; the bench also plays the register file.
module tb_mx_seu_pipe;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int FIDX  = 7;
   localparam int MASK  = 32'h3F08;

   logic                  clk = 1'b0;
   logic                  rst, in_valid, in_ready, ldi, fetch;
   logic [3:0]            opcode;
   logic [AW-1:0]         src_a, src_b, dst_f, wb_addr;
   logic [DW-1:0]         ldv, wb_data, wb_flags;
   logic [DEPTH*DW-1:0]   reg_line;
   logic                  wb_valid, wb_ready, wb_we, wb_bank, wb_flag_we;

   always #5 clk = ~clk;

   mx_seu_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .src_a(src_a), .src_b(src_b), .dst_f(dst_f), .ldi(ldi), .ldv(ldv), .fetch(fetch),
      .reg_line(reg_line), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
      .wb_addr(wb_addr), .wb_bank(wb_bank), .wb_data(wb_data), .wb_flag_we(wb_flag_we),
      .wb_flags(wb_flags)
   );

   logic [DW-1:0] regs      [DEPTH];
   logic [DW-1:0] init_regs [DEPTH];
   int            arch      [DEPTH];

   // Register file: flags written first so a data write to the flag register wins.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= init_regs[i];
      end else if (wb_valid && wb_ready) begin
         if (wb_flag_we) regs[FIDX] <= wb_flags;
         if (wb_we) regs[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      reg_line = '0;
      for (int i = 0; i < DEPTH; i++) reg_line[i*DW +: DW] = regs[i];
   end

   typedef struct {
      bit we;
      bit fe;
      int addr;
      bit bank;
      int data;
      int flags;
      int due;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0, n_miss = 0, cyc = 0;
   bit   rst_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= (1 << (DW - 1))) ? x - (1 << DW) : x;
   endfunction

   function automatic exp_t model(input int op, input int a, input int b, input int fl,
                                  input int dst, input bit fch);
      int m, h, full, sr, r, c, v, bb, cc, zf, nf, pf;
      exp_t e;
      m = 1 << DW; h = m / 2;
      r = 0; c = 0; v = 0; full = 0; sr = 0;
      e.we = 1'b1; e.fe = 1'b1;
      bb = (op == 12 || op == 13) ? 1 : b;
      cc = (op == 9 || op == 10) ? ((fl >> 3) & 1) : 0;
      case (op)
         0: r = a;
         1, 9, 12: begin
            full = a + bb + cc; r = full % m; c = (full >= m) ? 1 : 0;
            sr = sgn(a) + sgn(bb) + cc; v = (sr >= h || sr < -h) ? 1 : 0;
         end
         2, 10, 11, 13: begin
            full = a - bb - cc; r = (full + m) % m; c = (full < 0) ? 1 : 0;
            sr = sgn(a) - sgn(bb) - cc; v = (sr >= h || sr < -h) ? 1 : 0;
            if (op == 11) e.we = 1'b0;
         end
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = (m - 1) - a;
         7: begin full = a * 2; r = full % m; c = (full >= m) ? 1 : 0; end
         8: begin r = a / 2; c = a % 2; end
`ifdef MXSEU_MUL_EN
         14: begin full = a * b; r = full % m; c = (full >= m) ? 1 : 0; end
`endif
         default: begin e.we = 1'b0; e.fe = 1'b0; end
      endcase
      zf = (r == 0) ? 1 : 0;
      nf = (r >= h) ? 1 : 0;
      pf = ($countones(r) % 2 == 0) ? 1 : 0;
      e.data  = r;
      e.flags = (fl & ~31) + zf * 16 + c * 8 + nf * 4 + v * 2 + pf;
      e.addr  = dst;
      e.bank  = fch ? 1'b0 : 1'((MASK >> op) & 1);
      e.due   = 0;
      return e;
   endfunction

   // One clock: called just after a negedge with inputs applied; returns at the next negedge.
   task automatic tick();
      bit   exp_wbv, exp_busy;
      int   aa, lat;
      exp_t e;
      #1;
      exp_wbv  = (q.size() > 0) && (cyc >= q[0].due);
      exp_busy = (q.size() > 0) && (cyc < q[0].due);
      if (rst) begin
         check("in_ready_rst", in_ready, 0);
         if (rst_prev) check("wb_valid_rst", wb_valid, 0);
         q.delete();
         for (int i = 0; i < DEPTH; i++) arch[i] = int'(init_regs[i]);
      end else begin
         if (rst_prev) begin
            check("rst_wb_we", wb_we, 0);
            check("rst_wb_flag_we", wb_flag_we, 0);
            check("rst_wb_addr", wb_addr, 0);
            check("rst_wb_bank", wb_bank, 0);
            check("rst_wb_data", wb_data, 0);
            check("rst_wb_flags", wb_flags, 0);
         end
         check("wb_valid", wb_valid, exp_wbv);
         check("in_ready", in_ready, !exp_busy && (!exp_wbv || wb_ready));
         if (exp_wbv) begin
            e = q[0];
            check("wb_we", wb_we, e.we);
            check("wb_flag_we", wb_flag_we, e.fe);
            check("wb_bank", wb_bank, e.bank);
            if (e.we) begin
               check("wb_addr", wb_addr, e.addr);
               check("wb_data", wb_data, e.data);
            end
            if (e.fe) check("wb_flags", wb_flags, e.flags);
            if (wb_ready) void'(q.pop_front());
         end
         if (in_valid && in_ready) begin
            aa = ldi ? int'(ldv) : arch[src_a];
            e  = model(int'(opcode), aa, arch[src_b], arch[FIDX], int'(dst_f), fetch);
`ifdef MXSEU_MUL_EN
            lat = (opcode == 4'hE) ? DW : 1;
`else
            lat = 1;
`endif
            e.due = cyc + lat;
            if (e.fe) arch[FIDX] = e.flags;
            if (e.we) arch[dst_f] = e.data;
            q.push_back(e);
         end
      end
      rst_prev = rst;
      cyc++;
      @(negedge clk);
   endtask

   task automatic issue(input int op, input int sa, input int sb, input int dst, input bit li,
                        input int lv, input bit fch);
      in_valid = 1'b1;
      opcode   = 4'(op);
      src_a    = AW'(sa);
      src_b    = AW'(sb);
      dst_f    = AW'(dst);
      ldi      = li;
      ldv      = DW'(lv);
      fetch    = fch;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      in_valid = 1'b0; opcode = '0; src_a = '0; src_b = '0; dst_f = '0;
      ldi = 1'b0; ldv = '0; fetch = 1'b0; wb_ready = 1'b1; rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) init_regs[i] = DW'($urandom);
      init_regs[1] = 8'h7F;
      init_regs[2] = 8'h01;
      @(negedge clk);

      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 7F + 01 -> 80, then 80 - 01 forwarded back-to-back.
      issue(1, 1, 2, 3, 0, 0, 0);
      tick();
      check("add_data", wb_data, 8'h80);
      check("add_flags_zcnv", wb_flags[4:1], 4'b0011);
      check("add_bank", wb_bank, 0);
      issue(2, 3, 2, 4, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      check("sub_fwd_data", wb_data, 8'h7F);
      check("sub_fwd_addr", wb_addr, 4);

      // Back-pressure: four stalled cycles, then fire and accept together.
      wb_ready = 1'b0;
      issue(5, 1, 2, 6, 0, 0, 0);
      repeat (4) begin
         tick();
         check("stall_in_ready", in_ready, 0);
         check("stall_data", wb_data, 8'h7F);
      end
      wb_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("xor_after_stall", wb_data, 8'h7E);
      tick();

      // CMP with immediate against a just-written register, then fetch bank override.
      issue(0, 0, 0, 1, 1, 5, 0);
      tick();
      issue(11, 9, 1, 9, 1, 5, 0);
      tick();
      in_valid = 1'b0;
      check("cmp_we", wb_we, 0);
      check("cmp_flag_we", wb_flag_we, 1);
      check("cmp_zc", wb_flags[4:3], 2'b10);
      tick();
      issue(8, 3, 0, 10, 0, 0, 1);
      tick();
      check("shr_fetch_bank", wb_bank, 0);
      issue(8, 3, 0, 11, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      check("shr_bank", wb_bank, 1);
      tick();

`ifdef MXSEU_MUL_EN
      issue(0, 0, 0, 2, 1, 8'h11, 0);
      tick();
      issue(14, 0, 2, 12, 1, 8'h10, 0);
      tick();
      in_valid = 1'b0;
      repeat (DW - 1) begin
         check("mul_busy_valid", wb_valid, 0);
         check("mul_busy_ready", in_ready, 0);
         tick();
      end
      check("mul_valid", wb_valid, 1);
      check("mul_data", wb_data, 8'h10);
      check("mul_carry", wb_flags[3], 1);
      tick();
      issue(14, 0, 2, 13, 1, 8'h33, 0);
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (DW + 2) begin
         tick();
         check("mul_abort", wb_valid, 0);
      end
`endif

      repeat (1500) begin
         rst      = ($urandom_range(0, 299) == 0);
         wb_ready = ($urandom_range(0, 3) != 0);
         issue($urandom_range(0, 15), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
               $urandom_range(0, DEPTH - 1), ($urandom_range(0, 3) == 0),
               $urandom_range(0, 255), $urandom_range(0, 1) == 1);
         in_valid = ($urandom_range(0, 9) < 7);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
      repeat (DW + 2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
